switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16, meaning the number of consecutive clk cycles the synchronized input must hold a new level before it is accepted (legal range 2..65535).
REQ-002 The module SHALL have parameter CNT_W, default 16, meaning the stability counter width; STABLE_CYCLES SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 sw_in  input  1  raw, asynchronous, bouncing switch level.
REQ-006 d  output  1  debounced level, registered; drives the data input of the downstream D-behaviour flip-flop stage.
REQ-007 rise  output  1  one-cycle registered pulse when d goes 0->1.
REQ-008 fall  output  1  one-cycle registered pulse when d goes 1->0.
REQ-009 busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 sw_in SHALL pass through a 2-flop synchronizer (s1, s2); only s2 SHALL feed the FSM, giving 2 cycles of synchronizer latency.
REQ-011 The FSM SHALL have four states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-012 STABLE_LO: d=0, busy=0; if s2=1 go to QUAL_HI and load counter with 1, else remain.
REQ-013 QUAL_HI: busy=1; if s2=0 return to STABLE_LO and clear counter (bounce rejected, no pulse); else if counter = STABLE_CYCLES-1 go to STABLE_HI; else increment counter.
REQ-014 STABLE_HI: d=1, busy=0; if s2=0 go to QUAL_LO and load counter with 1, else remain.
REQ-015 QUAL_LO: busy=1; if s2=1 return to STABLE_HI and clear counter; else if counter = STABLE_CYCLES-1 go to STABLE_LO; else increment counter.
REQ-016 A level change on s2 held exactly STABLE_CYCLES cycles SHALL be accepted; one held STABLE_CYCLES-1 cycles SHALL be rejected.
REQ-017 d SHALL change in the same cycle the FSM enters STABLE_HI/STABLE_LO; total latency from sw_in edge to d change SHALL be STABLE_CYCLES+2 cycles.
REQ-018 rise SHALL be 1 for exactly the one cycle in which d first reads 1 after QUAL_HI; fall likewise for d first reading 0 after QUAL_LO; rise and fall SHALL never be 1 together.
REQ-019 A bounce that returns to the old level during qualification SHALL leave d unchanged and SHALL produce no pulse.
REQ-020 The counter SHALL saturate, never wrap; it SHALL be cleared in STABLE_LO and STABLE_HI.
REQ-021 Unreachable state encodings SHALL recover to STABLE_LO on the next clock with d=0.

Reset
REQ-022 While rst_n=0: s1=s2=0, state=STABLE_LO, counter=0, d=0, rise=0, fall=0, busy=0, applied asynchronously.
REQ-023 Reset asserted mid-qualification SHALL abort it with no pulse; after rst_n release with sw_in held 1, d SHALL rise STABLE_CYCLES+2 cycles after the first clock edge following release.

Verification
REQ-024 STABLE_CYCLES=4, sw_in 0->1 held -> busy=1 from cycle 3, d=1 and rise=1 at cycle 6, rise=0 at cycle 7.
REQ-025 STABLE_CYCLES=4, sw_in high for 3 cycles then low -> d stays 0, rise never asserts, busy returns to 0.
REQ-026 d=1 steady, sw_in toggles 1/0 every cycle for 20 cycles then holds 0 -> d stays 1 through toggling, fall=1 once, 6 cycles after final hold.
REQ-027 rst_n pulsed low during QUAL_HI -> d=0, busy=0 immediately; no rise emitted.
REQ-028 sw_in held 1 across reset release -> single rise, d=1 thereafter; rise and fall never simultaneous in any test.

Source files
------------

// File: rtl/switch_debounce.sv
// Switch debouncer: 2-flop synchronizer feeding a qualify/accept FSM.
// Emits a registered debounced level plus one-cycle rise/fall pulses.
module switch_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic d,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b10,
    QUAL_LO   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  logic s1;
  logic s2;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic d_nxt;
  logic rise_nxt;
  logic fall_nxt;
  logic busy_nxt;

  // Bring the raw switch level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      d     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      d     <= d_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next state and counter: a new level must persist to be accepted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: begin
        cnt_nxt = '0;
        if (s2) begin
          state_nxt = QUAL_HI;
          cnt_nxt   = ONE;
        end
      end
      QUAL_HI: begin
        if (!s2) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt != SAT) begin
          cnt_nxt = cnt + ONE;
        end
      end
      STABLE_HI: begin
        cnt_nxt = '0;
        if (!s2) begin
          state_nxt = QUAL_LO;
          cnt_nxt   = ONE;
        end
      end
      QUAL_LO: begin
        if (s2) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt != SAT) begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs track the state being entered so d moves with the FSM.
  always_comb begin
    d_nxt    = (state_nxt == STABLE_HI) ||
               (state_nxt == QUAL_LO);
    busy_nxt = (state_nxt == QUAL_HI) ||
               (state_nxt == QUAL_LO);
    rise_nxt = (state == QUAL_HI) &&
               (state_nxt == STABLE_HI);
    fall_nxt = (state == QUAL_LO) &&
               (state_nxt == STABLE_LO);
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: vector table, corner sequences,
// and random bounce patterns against a run-length reference model.
module tb_switch_debounce;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic sw_in;
  logic d;
  logic rise;
  logic fall;
  logic busy;

  int n_chk;
  int n_pass;

  switch_debounce #(
    .STABLE_CYCLES(N),
    .CNT_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .d    (d),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       sw;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: switch samples reach the FSM two edges late;
  // d flips once N consecutive samples disagree with it.
  logic m_pipe[$];
  logic m_d;
  logic m_rise;
  logic m_fall;
  logic m_busy;
  int   m_run;

  task automatic m_reset();
    m_pipe = '{1'b0, 1'b0};
    m_d    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_busy = 1'b0;
    m_run  = 0;
  endtask

  task automatic m_edge(input logic rst, input logic sw);
    logic smp;
    if (!rst) begin
      m_reset();
    end else begin
      smp = m_pipe.pop_front();
      m_pipe.push_back(sw);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (smp != m_d) begin
        m_run = m_run + 1;
        if (m_run == N) begin
          m_d    = ~m_d;
          m_rise = m_d;
          m_fall = ~m_d;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run > 0);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s got %b expected %b", nm, act, exp);
  endtask

  task automatic step(input logic rst, input logic sw);
    @(negedge clk);
    rst_n = rst;
    sw_in = sw;
    @(posedge clk);
    m_edge(rst, sw);
    #1;
  endtask

  function automatic void add(input logic r, input logic s,
                              input logic [3:0] e);
    vec_t v;
    v.rst = r;
    v.sw  = s;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  int   nrise;
  int   nfall;
  int   runleft;
  logic rsw;
  logic rrst;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    sw_in  = 1'b0;
    m_reset();

    // {d,rise,fall,busy} after each edge
    add(0, 0, 4'b0000);
    add(0, 0, 4'b0000);
    add(1, 1, 4'b0000);
    add(1, 1, 4'b0000);
    add(1, 1, 4'b0001);
    add(1, 1, 4'b0001);
    add(1, 1, 4'b0001);
    add(1, 1, 4'b1100);
    add(1, 1, 4'b1000);
    add(1, 1, 4'b1000);
    add(0, 0, 4'b0000);
    add(0, 0, 4'b0000);
    add(1, 1, 4'b0000);
    add(1, 1, 4'b0000);
    add(1, 1, 4'b0001);
    add(1, 0, 4'b0001);
    add(1, 0, 4'b0001);
    add(1, 0, 4'b0000);
    add(1, 0, 4'b0000);
    add(1, 0, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sw);
      chk($sformatf("vec%0d", i),
          {d, rise, fall, busy}, tbl[i].exp);
    end

    // Chatter while high, then a clean hold low.
    step(0, 0);
    for (int k = 0; k < 8; k++) step(1, 1);
    chk("hold_hi", {3'b000, d}, 4'b0001);
    nfall = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, i[0]);
      if (fall) nfall++;
      chk("chatter", {2'b00, d, fall}, 4'b0010);
    end
    for (int j = 1; j <= 10; j++) begin
      step(1, 0);
      if (fall) nfall++;
      if (j == 6)
        chk("fall_edge", {2'b00, d, fall}, 4'b0001);
      else if (j < 6)
        chk("pre_fall", {2'b00, d, fall}, 4'b0010);
      else
        chk("post_fall", {2'b00, d, fall}, 4'b0000);
    end
    chk("fall_cnt", 4'(nfall), 4'd1);

    // Reset in the middle of qualification.
    step(0, 0);
    for (int k = 0; k < 4; k++) step(1, 1);
    chk("qual_busy", {2'b00, d, busy}, 4'b0001);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {d, rise, fall, busy}, 4'b0000);
    m_reset();
    nrise = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0);
      if (rise) nrise++;
      chk("post_abort", {3'b000, d}, 4'b0000);
    end
    chk("abort_rise", 4'(nrise), 4'd0);

    // Switch already high while reset releases.
    step(0, 1);
    step(0, 1);
    nrise = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1, 1);
      if (rise) nrise++;
      if (k == 6)
        chk("rel_rise", {2'b00, d, rise}, 4'b0011);
      else if (k < 6)
        chk("rel_pre", {3'b000, d}, 4'b0000);
      else
        chk("rel_post", {2'b00, d, rise}, 4'b0010);
    end
    chk("rel_rise_cnt", 4'(nrise), 4'd1);

    // Random bounce runs against the model.
    step(0, 0);
    rsw     = 1'b0;
    runleft = 0;
    for (int c = 0; c < 3000; c++) begin
      if (runleft == 0) begin
        rsw     = ~rsw;
        runleft = $urandom_range(1, 7);
      end
      runleft = runleft - 1;
      rrst    = ($urandom_range(0, 499) != 0);
      step(rrst, rsw);
      chk("rand", {d, rise, fall, busy},
          {m_d, m_rise, m_fall, m_busy});
      chk("excl", {3'b000, rise & fall}, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
